// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with make/break/extended tracking, shift state and a show-ahead character FIFO.
// Optional caps-lock tracking is enabled by defining KBD_CAPS_LOCK_EN.
module ps2_ascii_decoder #(
    parameter int         FIFO_DEPTH    = 8,
    parameter logic [7:0] UNMAPPED_CHAR = 8'h2A,
    parameter int         DROP_UNMAPPED = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      scan_code,
    input  logic                            scan_valid,
    output logic [7:0]                      ascii_out,
    output logic                            ascii_valid,
    input  logic                            ascii_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    output logic                            shift_active,
    output logic                            caps_lock
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic shift_l;
    logic shift_r;
    logic set_l;
    logic set_r;
    logic clr_l;
    logic clr_r;
    logic push_req;
    logic [7:0] push_char;
    logic caps_now;
    logic [8:0] lut;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          do_push;
    logic          overflow_q;

    // Returns {hit, char}; hit=0 means the make code has no ASCII mapping.
    function automatic logic [8:0] decode(input logic [7:0] code, input logic shifted,
                                          input logic caps);
        logic [7:0] letter;
        logic [8:0] res;
        letter = 8'h00;
        res    = 9'h000;
        case (code)
            8'h1C: letter = "a";
            8'h32: letter = "b";
            8'h21: letter = "c";
            8'h23: letter = "d";
            8'h24: letter = "e";
            8'h2B: letter = "f";
            8'h34: letter = "g";
            8'h33: letter = "h";
            8'h43: letter = "i";
            8'h3B: letter = "j";
            8'h42: letter = "k";
            8'h4B: letter = "l";
            8'h3A: letter = "m";
            8'h31: letter = "n";
            8'h44: letter = "o";
            8'h4D: letter = "p";
            8'h15: letter = "q";
            8'h2D: letter = "r";
            8'h1B: letter = "s";
            8'h2C: letter = "t";
            8'h3C: letter = "u";
            8'h2A: letter = "v";
            8'h1D: letter = "w";
            8'h22: letter = "x";
            8'h35: letter = "y";
            8'h1A: letter = "z";
            default: letter = 8'h00;
        endcase
        if (letter != 8'h00) begin
            res = {1'b1, (shifted ^ caps) ? (letter - 8'h20) : letter};
        end else begin
            case (code)
                8'h45: res = {1'b1, shifted ? 8'h29 : 8'h30};
                8'h16: res = {1'b1, shifted ? 8'h21 : 8'h31};
                8'h1E: res = {1'b1, shifted ? 8'h40 : 8'h32};
                8'h26: res = {1'b1, shifted ? 8'h23 : 8'h33};
                8'h25: res = {1'b1, shifted ? 8'h24 : 8'h34};
                8'h2E: res = {1'b1, shifted ? 8'h25 : 8'h35};
                8'h36: res = {1'b1, shifted ? 8'h5E : 8'h36};
                8'h3D: res = {1'b1, shifted ? 8'h26 : 8'h37};
                8'h3E: res = {1'b1, shifted ? 8'h2A : 8'h38};
                8'h46: res = {1'b1, shifted ? 8'h28 : 8'h39};
                8'h0E: res = {1'b1, shifted ? 8'h7E : 8'h60};
                8'h4E: res = {1'b1, shifted ? 8'h5F : 8'h2D};
                8'h55: res = {1'b1, shifted ? 8'h2B : 8'h3D};
                8'h54: res = {1'b1, shifted ? 8'h7B : 8'h5B};
                8'h5B: res = {1'b1, shifted ? 8'h7D : 8'h5D};
                8'h5D: res = {1'b1, shifted ? 8'h7C : 8'h5C};
                8'h4C: res = {1'b1, shifted ? 8'h3A : 8'h3B};
                8'h52: res = {1'b1, shifted ? 8'h22 : 8'h27};
                8'h41: res = {1'b1, shifted ? 8'h3C : 8'h2C};
                8'h49: res = {1'b1, shifted ? 8'h3E : 8'h2E};
                8'h4A: res = {1'b1, shifted ? 8'h3F : 8'h2F};
                8'h29: res = {1'b1, 8'h20};
                8'h5A: res = {1'b1, 8'h0D};
                8'h66: res = {1'b1, 8'h08};
                8'h0D: res = {1'b1, 8'h09};
                8'h76: res = {1'b1, 8'h1B};
                default: res = 9'h000;
            endcase
        end
        return res;
    endfunction

`ifdef KBD_CAPS_LOCK_EN
    logic caps_q;
    logic caps_held;
    logic caps_make;
    logic caps_brk;

    // caps_held suppresses re-toggling while typematic repeats of 58 arrive.
    always_ff @(posedge clk) begin
        if (reset) begin
            caps_q    <= 1'b0;
            caps_held <= 1'b0;
        end else if (caps_make) begin
            if (!caps_held) caps_q <= ~caps_q;
            caps_held <= 1'b1;
        end else if (caps_brk) begin
            caps_held <= 1'b0;
        end
    end
    assign caps_now = caps_q;
`else
    assign caps_now = 1'b0;
`endif

    assign shift_active = shift_l | shift_r;
    assign caps_lock    = caps_now;
    assign lut          = decode(scan_code, shift_active, caps_now);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (scan_valid) begin
            case (state_q)
                IDLE: begin
                    if (scan_code == 8'hF0)      state_d = BRK;
                    else if (scan_code == 8'hE0) state_d = EXT;
                    else                         state_d = IDLE;
                end
                BRK:     state_d = IDLE;
                EXT:     state_d = (scan_code == 8'hF0) ? EXT_BRK : IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        push_req  = 1'b0;
        push_char = 8'h00;
        set_l     = 1'b0;
        set_r     = 1'b0;
        clr_l     = 1'b0;
        clr_r     = 1'b0;
`ifdef KBD_CAPS_LOCK_EN
        caps_make = 1'b0;
        caps_brk  = 1'b0;
`endif
        if (scan_valid) begin
            case (state_q)
                IDLE: begin
                    case (scan_code)
                        8'hF0, 8'hE0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
                        8'h12: set_l = 1'b1;
                        8'h59: set_r = 1'b1;
                        8'h58: begin
`ifdef KBD_CAPS_LOCK_EN
                            caps_make = 1'b1;
`endif
                        end
                        default: begin
                            if (lut[8]) begin
                                push_req  = 1'b1;
                                push_char = lut[7:0];
                            end else if (DROP_UNMAPPED == 0) begin
                                push_req  = 1'b1;
                                push_char = UNMAPPED_CHAR;
                            end
                        end
                    endcase
                end
                BRK: begin
                    case (scan_code)
                        8'h12: clr_l = 1'b1;
                        8'h59: clr_r = 1'b1;
                        8'h58: begin
`ifdef KBD_CAPS_LOCK_EN
                            caps_brk = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
                EXT: begin
                    if (scan_code == 8'h4A) begin
                        push_req  = 1'b1;
                        push_char = 8'h2F;
                    end else if (scan_code == 8'h5A) begin
                        push_req  = 1'b1;
                        push_char = 8'h0D;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else begin
            if (set_l)      shift_l <= 1'b1;
            else if (clr_l) shift_l <= 1'b0;
            if (set_r)      shift_r <= 1'b1;
            else if (clr_r) shift_r <= 1'b0;
        end
    end

    // Show-ahead FIFO: a pop in the same cycle frees the slot for a push even when full.
    assign full    = (count == FULL_COUNT);
    assign pop     = ascii_valid & ascii_ready;
    assign do_push = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_char;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow_q <= push_req & full & ~pop;
        end
    end

    assign ascii_valid = (count != '0);
    assign ascii_out   = ascii_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count  = count;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Scoreboard testbench for ps2_ascii_decoder; expectations adapt to KBD_CAPS_LOCK_EN.
module tb_ps2_ascii_decoder;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    scan_code = 8'h00;
    logic          scan_valid = 1'b0;
    logic [7:0]    ascii_out;
    logic          ascii_valid;
    logic          ascii_ready = 1'b0;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          shift_active;
    logic          caps_lock;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

`ifdef KBD_CAPS_LOCK_EN
    localparam logic CAPS_ON = 1'b1;
`else
    localparam logic CAPS_ON = 1'b0;
`endif

    ps2_ascii_decoder #(
        .FIFO_DEPTH(DEPTH),
        .UNMAPPED_CHAR(8'h2A),
        .DROP_UNMAPPED(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .scan_code(scan_code),
        .scan_valid(scan_valid),
        .ascii_out(ascii_out),
        .ascii_valid(ascii_valid),
        .ascii_ready(ascii_ready),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .shift_active(shift_active),
        .caps_lock(caps_lock)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the next negedge with the byte consumed.
    task automatic strobe(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        logic [7:0] e;
        budget = 200;
        ascii_ready = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            if (ascii_valid) begin
                e = exp_q.pop_front();
                checks++;
                if (ascii_out !== e) begin
                    failures++;
                    $display("FAIL drain_char: got %h expected %h", ascii_out, e);
                end
            end
            @(negedge clk);
            budget--;
        end
        ascii_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d characters never appeared", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (ascii_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_extra: ascii_valid=%b with out=%h, expected empty", ascii_valid, ascii_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (fifo_count !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++;
        if (ascii_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", ascii_valid); end
        checks++;
        if (ascii_out !== 8'h00) begin failures++; $display("FAIL reset_out: got %h expected 00", ascii_out); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++;
        if (shift_active !== 1'b0) begin failures++; $display("FAIL reset_shift: got %b expected 0", shift_active); end
        checks++;
        if (caps_lock !== 1'b0) begin failures++; $display("FAIL reset_caps: got %b expected 0", caps_lock); end
    endtask

    task automatic test_letter();
        strobe(8'h1C);
        exp_q.push_back(8'h61);
        checks++;
        if (ascii_valid !== 1'b1) begin failures++; $display("FAIL letter_latency: valid=%b expected 1", ascii_valid); end
        strobe(8'hF0);
        strobe(8'h1C);
        checks++;
        if (fifo_count !== CW'(1)) begin failures++; $display("FAIL letter_count: got %0d expected 1", fifo_count); end
        drain();
    endtask

    task automatic test_shift();
        strobe(8'h12);
        checks++;
        if (shift_active !== 1'b1) begin failures++; $display("FAIL shift_make: got %b expected 1", shift_active); end
        strobe(8'h1E);
        exp_q.push_back(8'h40);
        strobe(8'hF0);
        checks++;
        if (shift_active !== 1'b1) begin failures++; $display("FAIL shift_midbreak: got %b expected 1", shift_active); end
        strobe(8'h12);
        checks++;
        if (shift_active !== 1'b0) begin failures++; $display("FAIL shift_break: got %b expected 0", shift_active); end
        strobe(8'h1E);
        exp_q.push_back(8'h32);
        strobe(8'h59);
        strobe(8'h1C);
        exp_q.push_back(8'h41);
        strobe(8'hF0);
        strobe(8'h59);
        drain();
    endtask

    task automatic test_caps();
        strobe(8'h58);
        checks++;
        if (caps_lock !== CAPS_ON) begin failures++; $display("FAIL caps_first: got %b expected %b", caps_lock, CAPS_ON); end
        strobe(8'h58);
        strobe(8'h58);
        checks++;
        if (caps_lock !== CAPS_ON) begin failures++; $display("FAIL caps_repeat: got %b expected %b", caps_lock, CAPS_ON); end
        strobe(8'hF0);
        strobe(8'h58);
        strobe(8'h12);
        strobe(8'h1C);
        exp_q.push_back(CAPS_ON ? 8'h61 : 8'h41);
        strobe(8'hF0);
        strobe(8'h12);
        strobe(8'h16);
        exp_q.push_back(8'h31);
        strobe(8'h1C);
        exp_q.push_back(CAPS_ON ? 8'h41 : 8'h61);
        strobe(8'h58);
        strobe(8'hF0);
        strobe(8'h58);
        checks++;
        if (caps_lock !== 1'b0) begin failures++; $display("FAIL caps_off: got %b expected 0", caps_lock); end
        drain();
    endtask

    task automatic test_extended();
        strobe(8'hE0);
        strobe(8'h5A);
        exp_q.push_back(8'h0D);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h5A);
        strobe(8'hE0);
        strobe(8'h75);
        checks++;
        if (fifo_count !== CW'(1)) begin failures++; $display("FAIL ext_count: got %0d expected 1", fifo_count); end
        strobe(8'hE0);
        strobe(8'h4A);
        exp_q.push_back(8'h2F);
        strobe(8'h1C);
        exp_q.push_back(8'h61);
        drain();
    endtask

    task automatic test_symbols();
        logic [7:0] codes[8] = '{8'h0E, 8'h4E, 8'h52, 8'h29, 8'h66, 8'h0D, 8'h76, 8'h05};
        logic [7:0] chars[8] = '{8'h60, 8'h2D, 8'h27, 8'h20, 8'h08, 8'h09, 8'h1B, 8'h2A};
        for (int i = 0; i < 8; i++) begin
            strobe(codes[i]);
            exp_q.push_back(chars[i]);
            if (exp_q.size() == DEPTH) drain();
        end
        strobe(8'hE1);
        strobe(8'hAA);
        strobe(8'h12);
        strobe(8'h5D);
        exp_q.push_back(8'h7C);
        strobe(8'h4A);
        exp_q.push_back(8'h3F);
        strobe(8'h16);
        exp_q.push_back(8'h21);
        strobe(8'hF0);
        strobe(8'h12);
        strobe(8'h5D);
        exp_q.push_back(8'h5C);
        checks++;
        if (fifo_count !== CW'(exp_q.size())) begin
            failures++;
            $display("FAIL sym_count: got %0d expected %0d", fifo_count, exp_q.size());
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        logic [7:0] codes[4] = '{8'h1C, 8'h32, 8'h21, 8'h23};
        for (int i = 0; i < 4; i++) begin
            strobe(codes[i]);
            exp_q.push_back(8'h61 + 8'(i));
            checks++;
            if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early_%0d: got %b expected 0", i, overflow); end
        end
        strobe(8'h24);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
        checks++;
        if (fifo_count !== CW'(DEPTH)) begin failures++; $display("FAIL ovf_count: got %0d expected %0d", fifo_count, DEPTH); end
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_single: got %b expected 0", overflow); end
        e = exp_q.pop_front();
        checks++;
        if (ascii_out !== e) begin failures++; $display("FAIL ovf_head: got %h expected %h", ascii_out, e); end
        ascii_ready = 1'b1;
        strobe(8'h2B);
        ascii_ready = 1'b0;
        exp_q.push_back(8'h66);
        checks++;
        if (fifo_count !== CW'(DEPTH)) begin failures++; $display("FAIL ovf_pushpop_count: got %0d expected %0d", fifo_count, DEPTH); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pushpop: got %b expected 0", overflow); end
        drain();
    endtask

    task automatic test_reset_midseq();
        strobe(8'h1C);
        strobe(8'h32);
        strobe(8'h21);
        strobe(8'hE0);
        strobe(8'hF0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (fifo_count !== '0) begin failures++; $display("FAIL midrst_count: got %0d expected 0", fifo_count); end
        checks++;
        if (ascii_out !== 8'h00) begin failures++; $display("FAIL midrst_out: got %h expected 00", ascii_out); end
        strobe(8'h1C);
        exp_q.push_back(8'h61);
        checks++;
        if (fifo_count !== CW'(1)) begin failures++; $display("FAIL midrst_idle: got %0d expected 1", fifo_count); end
        drain();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_letter();
        test_shift();
        test_caps();
        test_extended();
        test_symbols();
        test_overflow();
        test_reset_midseq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_ascii_decoder.md
Name: ps2_ascii_decoder

Overview:
- Sequential successor to the combinational PS/2 set-2 scan-code lookup.
- Consumes the raw byte stream from the PS/2 receiver and tracks make/break (F0) and extended (E0) prefixes.
- Tracks the shift state and, optionally, caps-lock state, then produces case-correct ASCII.
- Queues characters in a parametrised FIFO, drained by a valid/ready consumer (UART tx, text display, etc.).

Parameters:
- FIFO_DEPTH, 8, character queue depth; power of two, 2..64.
- UNMAPPED_CHAR, 8'h2A, character pushed for an unmapped make code when DROP_UNMAPPED=0.
- DROP_UNMAPPED, 0, 1 = discard unmapped make codes silently.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scan_code  in  8  byte from the PS/2 receiver
- scan_valid  in  1  one-cycle strobe, scan_code valid; may assert on consecutive cycles
- ascii_out  out  8  FIFO head character; 8'h00 when empty
- ascii_valid  out  1  FIFO non-empty
- ascii_ready  in  1  consumer accepts head when ascii_valid & ascii_ready
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy
- overflow  out  1  one-cycle pulse when a character is dropped because the FIFO is full
- shift_active  out  1  left or right shift held
- caps_lock  out  1  caps-lock toggle state; constant 0 without KBD_CAPS_LOCK_EN

Behaviour:
- One clock domain. Reset is synchronous and active-high, on reset the block returns to:
  - FSM in IDLE
  - shift_l, shift_r, caps_lock and caps_held cleared
  - FIFO emptied: fifo_count=0, ascii_valid=0, ascii_out=8'h00
  - overflow=0
- Reset mid-prefix abandons the sequence; the next byte is decoded from IDLE.
- FSM advances only on scan_valid. States: IDLE, BRK, EXT, EXT_BRK.
  - IDLE:
    - F0 -> BRK.
    - E0 -> EXT.
    - 12 or 59 -> set shift_l or shift_r respectively; no output.
    - 58 -> caps handling (see Optional Feature); no output.
    - Any other byte -> decode and push; stay in IDLE.
  - BRK:
    - 12 or 59 -> clear the matching shift flag.
    - 58 -> clear caps_held.
    - Never outputs. -> IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - 4A -> push '/'.
    - 5A -> push 8'h0D.
    - Any other byte -> discard.
    - -> IDLE (except F0).
  - EXT_BRK: consume the byte, no output, -> IDLE.
  - E1 (Pause) and AA/FA/EE/FE in IDLE are discarded without a push; E1 and its trailing bytes decode as unmapped only if DROP_UNMAPPED=0 (accepted limitation).
- Decode (IDLE make codes); shift_active = shift_l | shift_r:
  - Letters: uppercase (41-5A) if shift_active XOR caps_lock, else lowercase (61-7A).
  - Digits 0-9: shifted gives ) ! @ # $ % ^ & * ( respectively.
  - Punctuation unshifted/shifted:
    - ` ~
    - - _
    - = +
    - [ {
    - ] }
    - \ |
    - ; :
    - ' "
    - , <
    - . >
    - / ?
  - Shift-invariant: space 29->20, enter 5A->0D, backspace 66->08, tab 0D->09, escape 76->1B.
  - Anything else is unmapped -> UNMAPPED_CHAR, or dropped if DROP_UNMAPPED=1.
- Latency: a byte strobed in cycle N is written at the clock edge ending cycle N. ascii_valid is high in cycle N+1 if the FIFO was empty. There is no combinational bypass.
- FIFO:
  - Show-ahead: ascii_out always equals the head.
  - Pop on ascii_valid & ascii_ready.
  - Push and pop in the same cycle: count unchanged. This is legal when full and no overflow occurs.
  - Push when full without a pop: character dropped, overflow pulses for that cycle, contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Shift state updates take effect for the byte following the shift make or break.

Optional Feature:
- Macro: KBD_CAPS_LOCK_EN.
- Defined:
  - Make 58 toggles caps_lock only when caps_held=0, then sets caps_held, so typematic repeats do not re-toggle.
  - Break 58 clears caps_held.
  - caps_lock affects letters only.
- Undefined:
  - caps_lock tied to 0 and no caps_held register.
  - Make/break 58 consumed with no output and no state change.

Test Plan:
- Reset, then strobe 1C, F0 1C -> FIFO holds one 8'h61 ('a'); ascii_valid rises the cycle after the strobe; fifo_count=1.
- Strobe 12, 1E, F0 12, 1E -> outputs 8'h40 ('@') then 8'h32 ('2'); shift_active=1 only between the 12 make and its break.
- With KBD_CAPS_LOCK_EN: strobe 58 58 58 F0 58, then 12 1C -> caps_lock=1 after the first 58 only, and it stays 1 through the repeats; shifted 'A' key yields 8'h61. Without the macro: same stimulus yields 8'h41, caps_lock=0.
- Strobe E0 5A, E0 F0 5A, E0 75 -> single 8'h0D pushed; 75 (up arrow) discarded; FSM back in IDLE.
- FIFO_DEPTH=4, ascii_ready=0: push 5 letters -> fifo_count=4, overflow pulses exactly once on the 5th push. Then assert ascii_ready with a simultaneous push -> no overflow, count stays 4, order preserved.
- Assert reset while in EXT_BRK with 3 queued characters -> next cycle fifo_count=0, ascii_out=8'h00. Subsequent 1C yields 8'h61.
